// File: rtl/unary_add_seq.sv
// Host-side sequencer for a serial unary adder: streams operands as unary pulses, then counts dout pulses back.
// Optional build macro UNARY_SELF_CHECK_EN adds a result/carry comparator driving mismatch.
module unary_add_seq #(
  parameter int W   = 3,
  parameter int TMO = (1 << W) + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         tmo,
  output logic         mismatch,
  output logic         u_en,
  output logic         u_rw,
  output logic         u_a,
  output logic         u_b,
  input  logic         u_dout,
  input  logic         u_c
);

  localparam int RW = $clog2(TMO + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_READ, S_FIN} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, k_q, k_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [W:0]   ones_q, ones_d;
  logic [W-1:0] result_q, result_d, n_m1;
  logic         busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic         u_en_q, u_en_d, u_rw_q, u_rw_d, u_a_q, u_a_d, u_b_q, u_b_d;
  logic         sampled, fin;
`ifdef UNARY_SELF_CHECK_EN
  logic         mism_q, mism_d;

  function automatic logic self_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] r, input logic ov, input logic t);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (r != s[W-1:0]) || (ov != s[W]) || t;
  endfunction
`endif

  // Last send index is max(a,b)-1; only used when at least one operand is nonzero.
  assign n_m1 = ((a_q > b_q) ? a_q : b_q) - {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    rcnt_d   = rcnt_q;
    ones_d   = ones_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    sampled  = 1'b0;
    fin      = 1'b0;
`ifdef UNARY_SELF_CHECK_EN
    mism_d   = mism_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          a_d      = op_a;
          b_d      = op_b;
          k_d      = '0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
`ifdef UNARY_SELF_CHECK_EN
          mism_d   = 1'b0;
`endif
          state_d  = (op_a == '0 && op_b == '0) ? S_GAP : S_SEND;
        end
      end
      S_SEND: begin
        // u_c lags by one cycle, so send cycle 0 carries nothing from this operation.
        if (k_q != '0 && u_c) ovf_d = 1'b1;
        if (k_q == n_m1) state_d = S_GAP;
        else             k_d = k_q + 1'b1;
      end
      S_GAP: begin
        if (u_c) ovf_d = 1'b1;
        rcnt_d  = '0;
        ones_d  = '0;
        state_d = S_READ;
      end
      S_READ: begin
        rcnt_d  = rcnt_q + 1'b1;
        sampled = (rcnt_q != '0);
        if (sampled && u_dout && ones_q != {(W+1){1'b1}}) ones_d = ones_q + 1'b1;
        if (sampled && !u_dout) begin
          fin = 1'b1;
        end else if (rcnt_q == RW'(TMO - 1)) begin
          tmo_d = 1'b1;
          fin   = 1'b1;
        end
        if (fin) begin
          state_d  = S_FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = ones_d[W-1:0];
`ifdef UNARY_SELF_CHECK_EN
          mism_d   = self_check(a_q, b_q, ones_d[W-1:0], ovf_q, tmo_d);
`endif
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Adder pins are registered from the next state so they line up with state_q.
    u_en_d = (state_d == S_SEND) || (state_d == S_GAP) || (state_d == S_READ);
    u_rw_d = (state_d == S_READ);
    u_a_d  = (state_d == S_SEND) && (k_d < a_d);
    u_b_d  = (state_d == S_SEND) && (k_d < b_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      rcnt_q   <= '0;
      ones_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      u_en_q   <= 1'b0;
      u_rw_q   <= 1'b0;
      u_a_q    <= 1'b0;
      u_b_q    <= 1'b0;
`ifdef UNARY_SELF_CHECK_EN
      mism_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      rcnt_q   <= rcnt_d;
      ones_q   <= ones_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      u_en_q   <= u_en_d;
      u_rw_q   <= u_rw_d;
      u_a_q    <= u_a_d;
      u_b_q    <= u_b_d;
`ifdef UNARY_SELF_CHECK_EN
      mism_q   <= mism_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign tmo    = tmo_q;
  assign u_en   = u_en_q;
  assign u_rw   = u_rw_q;
  assign u_a    = u_a_q;
  assign u_b    = u_b_q;
`ifdef UNARY_SELF_CHECK_EN
  assign mismatch = mism_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_unary_add_seq.sv
// Bench for unary_add_seq with a behavioural unary adder model on the u_* pins.
module tb_unary_add_seq;
  localparam int W   = 3;
  localparam int TMO = (1 << W) + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, ovf, tmo, mismatch;
  logic [W-1:0] result;
  logic         u_en, u_rw, u_a, u_b, u_dout, u_c;
  logic         mdl_dout, mdl_c, force_hi = 1'b0;
  logic [W-1:0] mdl_cnt;
  logic [W:0]   mdl_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unary_add_seq #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .tmo(tmo),
    .mismatch(mismatch), .u_en(u_en), .u_rw(u_rw), .u_a(u_a), .u_b(u_b),
    .u_dout(u_dout), .u_c(u_c)
  );

  // Adder model: read phase accumulates A+B mod 2^W with a registered carry pulse,
  // write phase emits one registered dout pulse per stored count.
  assign mdl_sum = {1'b0, mdl_cnt} + {{W{1'b0}}, u_a} + {{W{1'b0}}, u_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_cnt <= '0; mdl_dout <= 1'b0; mdl_c <= 1'b0;
    end else if (u_en && !u_rw) begin
      mdl_cnt <= mdl_sum[W-1:0]; mdl_c <= mdl_sum[W]; mdl_dout <= 1'b0;
    end else if (u_en && u_rw) begin
      mdl_dout <= (mdl_cnt != '0);
      if (mdl_cnt != '0) mdl_cnt <= mdl_cnt - 1'b1;
      mdl_c <= 1'b0;
    end else begin
      mdl_dout <= 1'b0; mdl_c <= 1'b0;
    end
  end
  assign u_dout = mdl_dout | (force_hi & u_rw);
  assign u_c    = mdl_c;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ov;
    int           lat;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_mism"}, mismatch, 0);
    chk({tag, "_uen"}, u_en, 0);
    chk({tag, "_urw"}, u_rw, 0);
    chk({tag, "_ua"}, u_a, 0);
    chk({tag, "_ub"}, u_b, 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int na, output int nb);
    bit got;
    lat = 0; na = 0; nb = 0; got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (u_a) na++;
      if (u_b) nb++;
      if (done) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, na, nb;
    logic [W-1:0] r;
    issue(v.a, v.b, 0);
    chk({tag, "_busy"}, busy, 1);
    wait_done(lat, na, nb);
    r = result;
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_result"}, result, v.res);
    chk({tag, "_ovf"}, ovf, v.ov);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_mism"}, mismatch, 0);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_na"}, na, v.a);
    chk({tag, "_nb"}, nb, v.b);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_hold"}, result, r);
  endtask

  initial begin
    int lat, na, nb, nd;
    logic exp_m;
    vt[0] = '{3'd3, 3'd2, 3'd5, 1'b0, 12};
    vt[1] = '{3'd0, 3'd0, 3'd0, 1'b0, 4};
    vt[2] = '{3'd7, 3'd7, 3'd6, 1'b1, 17};
    vt[3] = '{3'd4, 3'd4, 3'd0, 1'b1, 8};
    vt[4] = '{3'd1, 3'd1, 3'd2, 1'b0, 7};
    vt[5] = '{3'd5, 3'd0, 3'd5, 1'b0, 14};
    vt[6] = '{3'd0, 3'd6, 3'd6, 1'b0, 16};
    vt[7] = '{3'd6, 3'd3, 3'd1, 1'b1, 11};
    vt[8] = '{3'd7, 3'd1, 3'd0, 1'b1, 11};

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Reset during send cycle 2 of 5+2.
    issue(3'd5, 3'd2, 0);
    repeat (3) @(negedge clk);
    chk("midsend_ua", u_a, 1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midsend_rst");
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midsend_no_done", nd, 0);
    run_vec(vt[4], "after_rst");

    // dout stuck high in write phase forces the timeout path.
    force_hi = 1'b1;
    issue(3'd1, 3'd1, 0);
    wait_done(lat, na, nb);
    force_hi = 1'b0;
`ifdef UNARY_SELF_CHECK_EN
    exp_m = 1'b1;
`else
    exp_m = 1'b0;
`endif
    chk("tmo_lat", lat, 2 + 1 + TMO);
    chk("tmo_flag", tmo, 1);
    chk("tmo_mism", mismatch, exp_m);
    @(negedge clk);
    chk("tmo_hold", tmo, 1);

    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // start held every cycle through a 3+1 operation, then accepted right after FIN.
    issue(3'd3, 3'd1, 1);
    wait_done(lat, na, nb);
    chk("held_lat", lat, 11);
    chk("held_result", result, 4);
    chk("held_ovf", ovf, 0);
    op_a = 3'd2; op_b = 3'd3;
    @(posedge clk);
    #1;
    chk("fin_not_accepted", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done(lat, na, nb);
    chk("b2b_lat", lat, 12);
    chk("b2b_result", result, 5);
    chk("b2b_ovf", ovf, 0);
    chk("b2b_na", na, 2);
    chk("b2b_nb", nb, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
